// File: rtl/conv_pkg.sv
// Shared constants, array types and loader state for the conv_layer_2 operand loader.
package conv_pkg;

  localparam int unsigned BITWIDTH = 32;
  localparam int unsigned IN_CH    = 2;
  localparam int unsigned OUT_CH   = 2;
  localparam int unsigned FM_DIM   = 14;
  localparam int unsigned K_DIM    = 5;

  localparam int unsigned K_WORDS = OUT_CH * IN_CH * K_DIM * K_DIM;
  localparam int unsigned F_WORDS = IN_CH * FM_DIM * FM_DIM;

  localparam int unsigned LEVELS = 4;
  localparam int unsigned CNT_W  = 4;

  localparam int unsigned K_IW  = (K_DIM > 1) ? $clog2(K_DIM) : 1;
  localparam int unsigned F_IW  = (FM_DIM > 1) ? $clog2(FM_DIM) : 1;
  localparam int unsigned CH_IW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int unsigned OC_IW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  typedef logic signed [BITWIDTH-1:0] word_t;
  typedef word_t [IN_CH-1:0][FM_DIM-1:0][FM_DIM-1:0] fmap1_t;
  typedef word_t [OUT_CH-1:0][IN_CH-1:0][K_DIM-1:0][K_DIM-1:0] kernel2_t;
  typedef logic [LEVELS-1:0][CNT_W-1:0] raster_idx_t;

  typedef enum logic [1:0] {StIdle, StLoadK, StLoadF, StFull} load_state_t;

  // Level 0 is the fastest-moving index; each entry is that dimension's last index.
  localparam raster_idx_t K_LIMITS = {CNT_W'(OUT_CH - 1), CNT_W'(IN_CH - 1),
                                      CNT_W'(K_DIM - 1), CNT_W'(K_DIM - 1)};
  localparam raster_idx_t F_LIMITS = {CNT_W'(0), CNT_W'(IN_CH - 1),
                                      CNT_W'(FM_DIM - 1), CNT_W'(FM_DIM - 1)};

endpackage

// File: rtl/conv2_input_loader_if.sv
// Valid/ready word stream feeding the conv_layer_2 operand loader.
interface conv2_input_loader_if;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  conv_pkg::word_t  s_data;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/raster_counter.sv
// Four-level nested counter: level 0 steps on advance, outer levels step when all inner ones wrap.
module raster_counter
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        advance,
  input  raster_idx_t limits,
  output raster_idx_t idx,
  output logic        done
);

  raster_idx_t idx_q, idx_d;
  logic        carry;

  always_comb begin
    idx_d = idx_q;
    carry = advance;
    for (int l = 0; l < LEVELS; l++) begin
      if (carry) begin
        if (idx_q[l] == limits[l]) begin
          idx_d[l] = '0;
        end else begin
          idx_d[l] = idx_q[l] + CNT_W'(1);
          carry    = 1'b0;
        end
      end
    end
    if (clear) begin
      idx_d = '0;
    end
  end

  // done flags the position of the final element, i.e. the next advance wraps everything.
  always_comb begin
    done = 1'b1;
    for (int l = 0; l < LEVELS; l++) begin
      if (idx_q[l] != limits[l]) begin
        done = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/conv2_input_loader.sv
// Deserialises a word stream into the conv_layer_2 kernel and feature-map buffers and holds them
// stable until the consumer releases them.
module conv2_input_loader
  import conv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       keep_kernel,
  conv2_input_loader_if.slave        s,
  input  logic                       consume,
  output fmap1_t                     featuremap1,
  output kernel2_t                   kernel,
  output logic                       maps_valid,
  output logic                       frame_err
);

  load_state_t state_q, state_d;
  logic        frame_err_q, frame_err_d;
  fmap1_t      fmap_q;
  kernel2_t    kernel_q;

  logic        hs;
  logic        exp_last;
  logic        cnt_clear, cnt_adv, cnt_done;
  raster_idx_t cnt_limits, idx;
  logic        unused_idx;

  raster_counter u_raster_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .limits  (cnt_limits),
    .idx     (idx),
    .done    (cnt_done)
  );

  assign cnt_limits = (state_q == StLoadK) ? K_LIMITS : F_LIMITS;
  assign unused_idx = ^{idx[3][CNT_W-1:OC_IW], idx[2][CNT_W-1:CH_IW]};

  // s_ready depends on the state register only, never on s_valid.
  assign s.s_ready  = (state_q == StLoadK) || (state_q == StLoadF);
  assign hs         = s.s_valid & s.s_ready;
  assign exp_last   = (state_q == StLoadF) && cnt_done;
  assign maps_valid = (state_q == StFull);
  assign frame_err  = frame_err_q;

  always_comb begin
    state_d     = state_q;
    frame_err_d = frame_err_q;
    cnt_clear   = 1'b0;
    cnt_adv     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = keep_kernel ? StLoadF : StLoadK;
          cnt_clear   = 1'b1;
          frame_err_d = 1'b0;
        end
      end
      StLoadK: begin
        if (hs) begin
          cnt_adv = 1'b1;
          if (cnt_done) begin
            state_d   = StLoadF;
            cnt_clear = 1'b1;
          end
        end
      end
      StLoadF: begin
        if (hs) begin
          cnt_adv = 1'b1;
          if (cnt_done) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (consume) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (hs && (s.s_last != exp_last)) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kernel_q <= '0;
      fmap_q   <= '0;
    end else if (hs) begin
      if (state_q == StLoadK) begin
        kernel_q[idx[3][OC_IW-1:0]][idx[2][CH_IW-1:0]][idx[1][K_IW-1:0]][idx[0][K_IW-1:0]]
            <= s.s_data;
      end else begin
        fmap_q[idx[2][CH_IW-1:0]][idx[1][F_IW-1:0]][idx[0][F_IW-1:0]] <= s.s_data;
      end
    end
  end

  assign featuremap1 = fmap_q;
  assign kernel      = kernel_q;

endmodule

// File: doc/conv2_input_loader.md
Name: conv2_input_loader

Overview:
- Stream-to-array writer that fills the operand buffers of the second LeNet convolution stage (conv_layer_2).
- Accepts a valid/ready word stream and deserialises it into two buffers: the 2x2x5x5 kernel buffer and the 2x14x14 input feature-map buffer.
- Presents both buffers as whole arrays to the combinational conv layer, and holds them stable until the consumer releases them.

Parameters:
- BITWIDTH, 32, word width; two's-complement values, passed through unchanged.
- IN_CH, 2, input channels.
- OUT_CH, 2, output channels.
- FM_DIM, 14, input feature-map side length.
- K_DIM, 5, kernel side length.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE.
- keep_kernel  input  1  sampled with start; 1 skips the kernel phase and retains the current kernels.
- s_valid  input  1  stream word valid.
- s_ready  output  1  loader can accept a word.
- s_data  input  BITWIDTH  stream word.
- s_last  input  1  marks the final word of the load.
- consume  input  1  one-cycle pulse: downstream has captured its result and the buffers are released.
- featuremap1  output  BITWIDTH x [IN_CH][FM_DIM][FM_DIM]  feature-map buffer.
- kernel  output  BITWIDTH x [OUT_CH][IN_CH][K_DIM][K_DIM]  kernel buffer.
- maps_valid  output  1  both buffers are complete and stable.
- frame_err  output  1  sticky s_last framing error.

Behaviour:
- Reset values:
  - state = IDLE; all counters = 0.
  - s_ready = 0, maps_valid = 0, frame_err = 0.
  - Every featuremap1 and kernel element cleared to 0.
- Reset mid-load abandons the load; the next cycle is IDLE with the outputs above.
- States and transitions:
  - IDLE, s_ready = 0: start with keep_kernel = 0 -> LOAD_K; start with keep_kernel = 1 -> LOAD_F. frame_err clears on start.
  - LOAD_K, s_ready = 1: each handshake (s_valid & s_ready) writes s_data to kernel[o][i][r][c].
    - Order: c fastest, then r, then i, then o.
    - After the 100th word (OUT_CH*IN_CH*K_DIM*K_DIM) -> LOAD_F.
  - LOAD_F, s_ready = 1: each handshake writes featuremap1[ch][r][c].
    - Order: c fastest, then r, then ch.
    - After the 392nd word (IN_CH*FM_DIM*FM_DIM) -> FULL.
  - FULL, s_ready = 0, maps_valid = 1: consume -> IDLE; maps_valid drops the next cycle.
- Latency and timing:
  - A word accepted at edge N is visible on the array output after edge N.
  - maps_valid rises the cycle after the final handshake.
  - s_ready is registered and state-based, with no combinational path from s_valid.
  - Gaps in s_valid simply stall the counters.
- Framing:
  - Expected s_last is 1 only on the final word of the load: index 391 of LOAD_F, whether or not the kernel phase ran.
  - A handshake where s_last differs from the expected value sets frame_err.
  - Counting is not altered by a framing error; the load still completes on the word count.
  - frame_err stays set until the next accepted start or rst.
- Ignored events:
  - start outside IDLE is ignored.
  - consume outside FULL is ignored.
  - start and consume together in FULL: consume wins and start is dropped.
- Buffers are written only in LOAD_K and LOAD_F; they hold their contents in IDLE and FULL.
- A kernel phase skipped via keep_kernel leaves the previous kernels intact.
- Counters are nested per-dimension counters that wrap to 0 at dimension-1. The innermost counter advances on each handshake; each outer counter advances when all inner counters wrap.

Decomposition:
- Package conv_pkg:
  - Constants: BITWIDTH, IN_CH, OUT_CH, FM_DIM, K_DIM.
  - Typedefs: word_t, fmap1_t (IN_CH x FM_DIM x FM_DIM), kernel2_t (OUT_CH x IN_CH x K_DIM x K_DIM).
  - Loader state enum.
- One sub-module, raster_counter:
  - 4-level nested counter with per-level limits, advance and clear inputs.
  - Outputs: per-level indices and a done flag.
  - Instantiated once and reused for both phases (limits are muxed by state).

Test Plan:
- Reset, then start with keep_kernel = 0; stream 0..99 then 100..491, s_last on the final word.
  - Expect kernel[1][0][2][3] = 63 and featuremap1[1][13][13] = 491.
  - Expect maps_valid high 1 cycle after the final handshake, and frame_err = 0.
- Kernel load with [0][0] = 1, [0][1] = 0, [1][0] = 2, [1][1] = 3 (all taps). Feature map all 0 except [0][0][0] = 1, [1][0][0] = 5, [0][3][0] = 10, [1][3][0] = -5. Drive conv_layer_2 from the loader.
  - Expect featuremap2[0][0][0] = 11, [1][0][0] = 22, [1][3][0] = 5.
- Random s_valid gaps (about 30% idle); start pulsed mid-load; consume pulsed during a load.
  - Expect an identical final image, and both pulses ignored.
- After consume, start with keep_kernel = 1 and stream 392 words.
  - Expect kernels unchanged and maps_valid high after the 392nd word.
- s_last asserted on word 50 and not on the final word.
  - Expect frame_err = 1 from word 50 onwards, and the load still completes on the word count.
  - Expect frame_err cleared by the next start.
- rst asserted at LOAD_F word 200.
  - Expect all array elements 0, s_ready = 0, maps_valid = 0 on the next cycle.
  - Expect a fresh start to load cleanly.
